// File: rtl/apb_timer_if.sv
// APB slave bus bundle for apb_timer; PRDATA is driven combinationally by the slave.
// Zero wait states: no PREADY/PSLVERR, so the master never observes backpressure.
interface apb_timer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [4:0]  PADDR;
  logic [31:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PWDATA, PADDR, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PWDATA, PADDR, output PRDATA);
endinterface

// File: rtl/apb_timer.sv
// APB down-counting timer with prescaler, periodic/one-shot modes and a level IRQ.
// Writes land on the access edge, reads are combinational, irq_out lags EXPIRED/IE by 1 clk; no backpressure.
module apb_timer #(
  parameter int CNT_WIDTH = 32,
  parameter int PS_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  apb_timer_if.slave apb,
  output logic       irq_out
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_RELOAD   = 3'd2;
  localparam logic [2:0] A_VALUE    = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;

  logic                 r_en;
  logic                 r_periodic;
  logic                 r_ie;
  logic [PS_WIDTH-1:0]  r_prescale;
  logic [PS_WIDTH-1:0]  r_ps_cnt;
  logic [CNT_WIDTH-1:0] r_reload;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_expired;

  logic [2:0]  w_addr;
  logic        w_acc;
  logic        w_wr_ctrl;
  logic        w_wr_prescale;
  logic        w_wr_reload;
  logic        w_wr_value;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_cnt_zero;
  logic        w_expire;
  logic        w_en_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_addr        = apb.PADDR[4:2];
  assign w_acc         = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_wr_ctrl     = w_acc && (w_addr == A_CTRL);
  assign w_wr_prescale = w_acc && (w_addr == A_PRESCALE);
  assign w_wr_reload   = w_acc && (w_addr == A_RELOAD);
  assign w_wr_value    = w_acc && (w_addr == A_VALUE);
  assign w_wr_status   = w_acc && (w_addr == A_STATUS);

  assign w_tick     = r_en && (r_ps_cnt == r_prescale);
  assign w_cnt_zero = (r_count == '0);
  // A VALUE write on a tick edge owns the counter, so it also masks expiry.
  assign w_expire   = w_tick && w_cnt_zero && !w_wr_value;
  assign w_en_nxt   = w_wr_ctrl ? apb.PWDATA[0] : (r_en && !(w_expire && !r_periodic));

  assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_prescale <= '0;
      r_ps_cnt   <= '0;
      r_reload   <= '0;
      r_count    <= '0;
      r_expired  <= 1'b0;
      irq_out    <= 1'b0;
    end else begin
      r_en <= w_en_nxt;
      if (w_wr_ctrl) begin
        r_periodic <= apb.PWDATA[1];
        r_ie       <= apb.PWDATA[2];
      end
      if (w_wr_prescale) r_prescale <= apb.PWDATA[PS_WIDTH-1:0];
      if (w_wr_reload)   r_reload   <= apb.PWDATA[CNT_WIDTH-1:0];

      // Prescaler restarts its phase on enable, disable, tick and VALUE writes.
      if (w_wr_value || !r_en || !w_en_nxt || w_tick)
        r_ps_cnt <= '0;
      else
        r_ps_cnt <= r_ps_cnt + PS_WIDTH'(1);

      if (w_wr_value)
        r_count <= apb.PWDATA[CNT_WIDTH-1:0];
      else if (w_tick) begin
        if (!w_cnt_zero)
          r_count <= r_count - CNT_WIDTH'(1);
        else if (r_periodic)
          r_count <= r_reload;
      end

      if (w_expire)
        r_expired <= 1'b1;
      else if (w_wr_status && apb.PWDATA[0])
        r_expired <= 1'b0;

      irq_out <= r_expired & r_ie;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      A_CTRL:     w_rdata[2:0] = {r_ie, r_periodic, r_en};
      A_PRESCALE: w_rdata[PS_WIDTH-1:0] = r_prescale;
      A_RELOAD:   w_rdata[CNT_WIDTH-1:0] = r_reload;
      A_VALUE:    w_rdata[CNT_WIDTH-1:0] = r_count;
      A_STATUS:   w_rdata[0] = r_expired;
      default:    w_rdata = '0;
    endcase
  end

  assign apb.PRDATA = w_rdata;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: register table, then timed sequences for expiry, races and reset.
module tb_apb_timer;

  localparam logic [4:0] A_CTRL = 5'h00, A_PS = 5'h04, A_RLD = 5'h08, A_VAL = 5'h0c, A_ST = 5'h10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq_out;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  apb_timer_if u_if ();

  apb_timer #(.CNT_WIDTH(32), .PS_WIDTH(16)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .apb     (u_if),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic sb_push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0x%08h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    u_if.PADDR = a; u_if.PWDATA = d; u_if.PWRITE = 1'b1; u_if.PSEL = 1'b1; u_if.PENABLE = 1'b0;
    @(negedge clk);
    u_if.PENABLE = 1'b1;
    @(posedge clk);
    #1;
    u_if.PSEL = 1'b0; u_if.PENABLE = 1'b0; u_if.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    u_if.PADDR = a; u_if.PWRITE = 1'b0; u_if.PSEL = 1'b1; u_if.PENABLE = 1'b1;
    #1;
    d = u_if.PRDATA;
    u_if.PSEL = 1'b0; u_if.PENABLE = 1'b0;
  endtask

  task automatic check_rd(input logic [4:0] a, input logic [31:0] exp, input string n);
    logic [31:0] d;
    sb_push(n, exp);
    apb_read(a, d);
    sb_pop(d);
  endtask

  task automatic check_irq(input logic exp, input string n);
    sb_push(n, {31'b0, exp});
    sb_pop({31'b0, irq_out});
  endtask

  task automatic wait_irq(input logic lvl, input int maxc, output int stamp);
    stamp = -1;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (irq_out === lvl) begin
        stamp = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int w, r1, r2, st;
    logic [31:0] d;
    logic found;

    vt[0]  = '{1'b1, A_CTRL, 32'h0000_0006, 32'h0000_0006};
    vt[1]  = '{1'b1, A_CTRL, 32'hFFFF_FFF8, 32'h0000_0000};
    vt[2]  = '{1'b1, A_PS,   32'hFFFF_FFFF, 32'h0000_FFFF};
    vt[3]  = '{1'b1, A_RLD,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[4]  = '{1'b1, A_VAL,  32'h1234_5678, 32'h1234_5678};
    vt[5]  = '{1'b0, 5'h0b,  32'h0,         32'hDEAD_BEEF};
    vt[6]  = '{1'b1, A_ST,   32'h0000_0001, 32'h0000_0000};
    vt[7]  = '{1'b1, 5'h14,  32'hFFFF_FFFF, 32'h0000_0000};
    vt[8]  = '{1'b1, 5'h18,  32'h0000_A5A5, 32'h0000_0000};
    vt[9]  = '{1'b1, 5'h1c,  32'h0000_0001, 32'h0000_0000};
    vt[10] = '{1'b0, A_VAL,  32'h0,         32'h1234_5678};

    u_if.PSEL = 1'b0; u_if.PENABLE = 1'b0; u_if.PWRITE = 1'b0;
    u_if.PWDATA = '0; u_if.PADDR = '0;
    do_reset();
    check_irq(1'b0, "reset_irq");
    check_rd(A_CTRL, 32'h0, "reset_ctrl");
    check_rd(A_VAL, 32'h0, "reset_value");

    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) apb_write(vt[i].addr, vt[i].wdata);
      check_rd(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Periodic: first irq 21 clk after enable, then 20 clk period.
    do_reset();
    apb_write(A_PS, 32'd3);
    apb_write(A_RLD, 32'd4);
    apb_write(A_VAL, 32'd4);
    apb_write(A_CTRL, 32'h7);
    w = cyc;
    wait_irq(1'b1, 100, r1);
    sb_push("periodic_first_delay", 32'd21);
    sb_pop((r1 < 0) ? 32'hFFFF_FFFF : 32'(r1 - w));
    check_rd(A_ST, 32'h1, "periodic_status");
    apb_write(A_ST, 32'h1);
    check_irq(1'b1, "w1c_irq_same_cycle");
    @(posedge clk); #1;
    check_irq(1'b0, "w1c_irq_falls");
    wait_irq(1'b1, 100, r2);
    sb_push("periodic_period", 32'd20);
    sb_pop((r1 < 0 || r2 < 0) ? 32'hFFFF_FFFF : 32'(r2 - r1));

    // Reset asserted mid-run with irq high.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_irq(1'b0, "midrun_reset_irq");
    check_rd(A_CTRL, 32'h0, "rst_low_ctrl");
    check_rd(A_PS, 32'h0, "rst_low_prescale");
    check_rd(A_RLD, 32'h0, "rst_low_reload");
    check_rd(A_VAL, 32'h0, "rst_low_value");
    check_rd(A_ST, 32'h0, "rst_low_status");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_irq(1'b0, "rst_release_irq");
    check_rd(A_VAL, 32'h0, "rst_release_value");
    check_rd(A_ST, 32'h0, "rst_release_status");

    // One-shot: expiry on the third tick, EN self-clears, count parks at 0.
    do_reset();
    apb_write(A_PS, 32'd0);
    apb_write(A_VAL, 32'd2);
    apb_write(A_CTRL, 32'h5);
    w = cyc;
    wait_irq(1'b1, 50, r1);
    sb_push("oneshot_irq_delay", 32'd4);
    sb_pop((r1 < 0) ? 32'hFFFF_FFFF : 32'(r1 - w));
    check_rd(A_CTRL, 32'h4, "oneshot_ctrl");
    repeat (50) @(posedge clk);
    #1;
    check_rd(A_VAL, 32'h0, "oneshot_value_held");
    check_rd(A_ST, 32'h1, "oneshot_status_held");

    // W1C landing on the expiry edge: set wins.
    do_reset();
    apb_write(A_PS, 32'd0);
    apb_write(A_VAL, 32'd2);
    apb_write(A_CTRL, 32'h5);
    @(posedge clk);
    apb_write(A_ST, 32'h1);
    check_rd(A_ST, 32'h1, "race_set_wins");
    @(posedge clk); #1;
    check_irq(1'b1, "race_irq_rises");
    apb_write(A_ST, 32'h1);
    check_rd(A_ST, 32'h0, "late_w1c_clears");
    @(posedge clk); #1;
    check_irq(1'b0, "late_w1c_irq_falls");

    // IE gating.
    do_reset();
    apb_write(A_PS, 32'd0);
    apb_write(A_VAL, 32'd1);
    apb_write(A_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check_rd(A_ST, 32'h1, "gated_status");
    check_irq(1'b0, "gated_irq_low");
    apb_write(A_CTRL, 32'h4);
    check_irq(1'b0, "ie_set_same_cycle");
    @(posedge clk); #1;
    check_irq(1'b1, "ie_set_irq_next");

    // Live reload at count 7 restarts the prescaler phase.
    do_reset();
    apb_write(A_PS, 32'd3);
    apb_write(A_VAL, 32'd20);
    apb_write(A_CTRL, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      apb_read(A_VAL, d);
      if (d == 32'd7) begin
        found = 1'b1;
        break;
      end
    end
    sb_push("live_count7_seen", 32'h1);
    sb_pop({31'b0, found});
    apb_write(A_VAL, 32'd100);
    check_rd(A_VAL, 32'd100, "live_reload_value");
    repeat (3) @(posedge clk);
    #1;
    check_rd(A_VAL, 32'd100, "live_phase_restart");
    @(posedge clk); #1;
    check_rd(A_VAL, 32'd99, "live_first_decrement");
    check_rd(A_ST, 32'h0, "live_no_expiry");

    // VALUE write coinciding with a tick: write wins over decrement.
    do_reset();
    apb_write(A_PS, 32'd0);
    apb_write(A_VAL, 32'd50);
    apb_write(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    apb_write(A_VAL, 32'd5);
    check_rd(A_VAL, 32'd5, "value_vs_tick");
    @(posedge clk); #1;
    check_rd(A_VAL, 32'd4, "value_then_decrement");

    // CTRL write on the one-shot expiry edge keeps EN; RELOAD=0 periodic then fires every tick.
    do_reset();
    apb_write(A_PS, 32'd0);
    apb_write(A_VAL, 32'd1);
    apb_write(A_CTRL, 32'h1);
    apb_write(A_CTRL, 32'h3);
    check_rd(A_CTRL, 32'h3, "ctrl_vs_autoclear");
    check_rd(A_ST, 32'h1, "ctrl_race_expired");
    apb_write(A_ST, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check_rd(A_ST, 32'h1, "reload0_every_tick");
    check_rd(A_VAL, 32'h0, "reload0_count");

    st = sb_q.size();
    sb_push("scoreboard_drained", 32'h0);
    sb_pop(32'(st));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
